// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if -- bundle for the PS/2 host-to-device transmitter.
//
// Groups the command handshake, the status flags and the open-drain pad
// signals of one PS/2 port.
//   tx_data[7:0]  command byte to send, LSB first
//   tx_valid      request from the command source
//   tx_ready      transmitter idle and able to accept a byte
//   busy          frame in flight; the keyboard receiver ignores the lines
//   done          one-cycle pulse, device ACKed and the bus went idle
//   err           one-cycle pulse, timeout or missing ACK
//   ps2_clk       raw PS/2 clock line as seen at the pad
//   ps2_data      raw PS/2 data line as seen at the pad
//   ps2_clk_oe    1 = pull ps2_clk low
//   ps2_data_oe   1 = pull ps2_data low
//
// master : command source plus pad side (drives request and line levels)
// slave  : the transmitter itself
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk, ps2_data,
    input  tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk, ps2_data,
    output tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 keyboard: inhibits the bus by holding
// ps2_clk low, issues the start bit, shifts out 8 data bits LSB first, odd
// parity and a released stop bit on successive device clock falling edges,
// then checks the device ACK and waits for the bus to return idle.
// Both lines are driven open-drain through active-high pull-low enables.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset (lines released immediately)
//   bus   ps2_host_tx_if.slave (tx_data/tx_valid/tx_ready, busy, done,
//         err, ps2_clk/ps2_data inputs, ps2_clk_oe/ps2_data_oe outputs)
//
// Parameters:
//   INHIBIT_CYC  clk cycles ps2_clk is held low before the start bit
//   TIMEOUT_CYC  max clk cycles between device edges / waiting for idle
//   RETRIES      extra attempts after a failed frame
//
// Build option: define PS2_TX_RETRY_EN to retry a failed frame up to
// RETRIES times before reporting err. Without it the first failure
// reports err and returns to idle.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int RETRIES     = 2
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);

  localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_TX,
    S_ACK,
    S_WAIT_IDLE,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             load;
  logic [7:0]       data_q;
  logic             par_q;

  logic [2:0]       clk_sync_q;
  logic [2:0]       dat_sync_q;
  logic             clk_prev_q;
  logic             clk_s;
  logic             dat_s;
  logic             fall;
  logic             tmo;

`ifdef PS2_TX_RETRY_EN
  localparam int RTY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  logic [RTY_W-1:0] retry_q, retry_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retry_q <= '0;
    else     retry_q <= retry_d;
  end
`else
  // RETRIES only matters when retries are built in.
  logic unused_retries;
  assign unused_retries = (RETRIES != 0);
`endif

  // Three-flop synchronisers; reset to the idle (high) level so no edge is
  // seen coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], bus.ps2_data};
      clk_prev_q <= clk_sync_q[2];
    end
  end

  assign clk_s = clk_sync_q[2];
  assign dat_s = dat_sync_q[2];
  assign fall  = clk_prev_q & ~clk_s;
  assign tmo   = (cnt_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // The byte is only captured at accept, so tx_data may change freely
  // while a frame (and any retry of it) is on the wire.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= bus.tx_data;
      par_q  <= ~^bus.tx_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    // Edge-timed states restart the timeout on every device falling edge.
    if (state_q == S_START || state_q == S_TX ||
        state_q == S_ACK   || state_q == S_WAIT_IDLE) begin
      if (fall) cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        if (bus.tx_valid) begin
          load    = 1'b1;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = '0;
`endif
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_d     = '0;
          data_oe_d = 1'b1;
        end
      end

      S_START: begin
        if (fall) begin
          state_d   = S_TX;
          bit_d     = 4'd1;
          data_oe_d = ~data_q[0];
        end else if (tmo) begin
          state_d   = S_FAIL;
          cnt_d     = '0;
          data_oe_d = 1'b0;
        end
      end

      // bit_q holds the number of edges already seen, so the new edge is
      // number bit_q+1 and carries data bit bit_q.
      S_TX: begin
        if (fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            data_oe_d = ~data_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end else if (tmo) begin
          state_d   = S_FAIL;
          cnt_d     = '0;
          data_oe_d = 1'b0;
        end
      end

      S_ACK: begin
        if (fall) begin
          state_d = dat_s ? S_FAIL : S_WAIT_IDLE;
        end else if (tmo) begin
          state_d = S_FAIL;
          cnt_d   = '0;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tmo) begin
          state_d = S_FAIL;
          cnt_d   = '0;
        end
      end

      S_FAIL: begin
        data_oe_d = 1'b0;
        cnt_d     = '0;
`ifdef PS2_TX_RETRY_EN
        if (retry_q < RTY_W'(RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_INHIBIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`else
        err_d   = 1'b1;
        state_d = S_IDLE;
`endif
      end

      default: begin
        state_d   = S_IDLE;
        data_oe_d = 1'b0;
      end
    endcase
  end

  // Line enables decode straight from registered state so an async reset
  // releases both lines at once.
  assign bus.ps2_clk_oe  = (state_q == S_INHIBIT);
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.tx_ready    = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 2000;
  localparam int TMO  = 1500;
  localparam int RTY  = 2;
  localparam int HALF = 15;
  localparam int LIM  = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_lo  = 1'b0;
  logic dev_data_lo = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] acc_q[$];

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TMO),
    .RETRIES    (RTY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Open-drain wiring: a line is low when either side pulls it.
  assign bus.ps2_clk  = ~(bus.ps2_clk_oe  | dev_clk_lo);
  assign bus.ps2_data = ~(bus.ps2_data_oe | dev_data_lo);

  always #5 clk = ~clk;

  // Bus observer: records every accepted byte and counts status pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid && bus.tx_ready) acc_q.push_back(bus.tx_data);
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.err)  err_cnt  <= err_cnt + 1;
      if (bus.done && bus.err) both_cnt <= both_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  // Expected 11-bit wire image: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    chk("send_busy", bus.busy, 1'b1);
  endtask

  // Keyboard model: waits out the inhibit, then clocks 11 pulses, reading
  // each bit while the clock is high. abort_at stops with the clock held low.
  task automatic dev_frame(input bit ack, input int abort_at,
                           output logic [10:0] bits, output int inh_len);
    int n;
    bits    = '1;
    inh_len = 0;
    @(negedge clk);
    n = 0;
    while (bus.ps2_clk_oe !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("dev_inhibit_seen", bus.ps2_clk_oe, 1'b1);
    while (bus.ps2_clk_oe === 1'b1 && inh_len < LIM) begin inh_len++; @(negedge clk); end
    repeat (10) @(negedge clk);
    bits[0] = bus.ps2_data;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data_lo = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == abort_at) return;
      dev_clk_lo = 1'b0;
      if (k == 11) dev_data_lo = 1'b0;
      else         bits[k] = bus.ps2_data;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_done"},  bus.done,     1'b1);
    chk({tag, "_rdy"},   bus.tx_ready, 1'b1);
    chk({tag, "_noerr"}, bus.err,      1'b0);
  endtask

  task automatic good_frame(input string tag, output logic [10:0] bits);
    int inh, dc, sz;
    logic [7:0] exp_b;
    dc = done_cnt;
    dev_frame(1'b1, 0, bits, inh);
    chk({tag, "_inhibit_len"}, inh, INH);
    wait_done(tag);
    sz = acc_q.size();
    chk({tag, "_accepts"}, sz, 1);
    exp_b = (sz > 0) ? acc_q.pop_front() : 8'h00;
    chk({tag, "_wire"}, bits, frame_bits(exp_b));
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - dc, 1);
  endtask

  task automatic wait_clk_oe(input logic lvl, input string tag);
    int n;
    n = 0;
    while (bus.ps2_clk_oe !== lvl && n < LIM) begin @(negedge clk); n++; end
    chk(tag, bus.ps2_clk_oe, lvl);
  endtask

  initial begin
    logic [10:0] bits, bits2;
    logic [7:0]  b;
    int inh, n, dc, ec, att, tn;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    repeat (3) @(posedge clk); #1;
    chk("rst_tx_ready", bus.tx_ready,    1'b1);
    chk("rst_busy",     bus.busy,        1'b0);
    chk("rst_done",     bus.done,        1'b0);
    chk("rst_err",      bus.err,         1'b0);
    chk("rst_clk_oe",   bus.ps2_clk_oe,  1'b0);
    chk("rst_data_oe",  bus.ps2_data_oe, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // LED-set command with a spelled-out wire image
    send(8'hED);
    good_frame("ed", bits);
    chk("ed_literal", bits, 11'h7DA);

    send(8'h00);
    good_frame("x00", bits);
    chk("x00_parity", bits[9], 1'b1);

    send(8'hFF);
    good_frame("xff", bits);
    chk("xff_parity", bits[9], 1'b1);

    send(8'h01);
    good_frame("x01", bits);
    chk("x01_parity", bits[9], 1'b0);

    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send(b);
      good_frame("rnd", bits);
    end

    // Device never clocks: timeout after START
    dc = done_cnt;
    ec = err_cnt;
    send(8'h5A);
`ifdef PS2_TX_RETRY_EN
    att = RTY + 1;
`else
    att = 1;
`endif
    for (int a = 0; a < att; a++) begin
      wait_clk_oe(1'b1, "tmo_inhibit_on");
      wait_clk_oe(1'b0, "tmo_inhibit_off");
    end
    n = 0;
    while (bus.err !== 1'b1 && n < 3 * TMO) begin @(negedge clk); n++; end
    chk("tmo_window",  (n >= TMO && n <= TMO + 2), 1'b1);
    chk("tmo_clk_oe",  bus.ps2_clk_oe,  1'b0);
    chk("tmo_data_oe", bus.ps2_data_oe, 1'b0);
    repeat (3) @(negedge clk);
    chk("tmo_err_once", err_cnt - ec, 1);
    chk("tmo_no_done",  done_cnt - dc, 0);
    if (acc_q.size() > 0) b = acc_q.pop_front();

    // Device leaves data high at edge 11
    dc = done_cnt;
    ec = err_cnt;
    send(8'h3C);
`ifdef PS2_TX_RETRY_EN
    dev_frame(1'b0, 0, bits, inh);
    dev_frame(1'b1, 0, bits2, inh);
    chk("rty_second_inhibit", (inh > 0), 1'b1);
    wait_done("rty");
    chk("rty_wire", bits2, frame_bits(8'h3C));
    repeat (3) @(negedge clk);
    chk("rty_no_err", err_cnt - ec, 0);
    chk("rty_done",   done_cnt - dc, 1);
    chk("rty_busy",   bus.busy, 1'b0);
`else
    dev_frame(1'b0, 0, bits, inh);
    chk("nack_clk_oe",  bus.ps2_clk_oe,  1'b0);
    chk("nack_data_oe", bus.ps2_data_oe, 1'b0);
    repeat (5) @(negedge clk);
    chk("nack_err",     err_cnt - ec, 1);
    chk("nack_no_done", done_cnt - dc, 0);
    chk("nack_rdy",     bus.tx_ready, 1'b1);
    chk("nack_wire",    bits, frame_bits(8'h3C));
`endif
    if (acc_q.size() > 0) b = acc_q.pop_front();

    // Reset while edge 5 is being served (bit 4 of 0xED is 0, so data pulled)
    dc = done_cnt;
    ec = err_cnt;
    send(8'hED);
    dev_frame(1'b1, 5, bits, inh);
    chk("rstmid_pre_data_oe", bus.ps2_data_oe, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("rstmid_data_oe", bus.ps2_data_oe, 1'b0);
    chk("rstmid_clk_oe",  bus.ps2_clk_oe,  1'b0);
    chk("rstmid_busy",    bus.busy,        1'b0);
    dev_clk_lo = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    if (acc_q.size() > 0) b = acc_q.pop_front();
    repeat (5) @(negedge clk);
    chk("rstmid_rdy",     bus.tx_ready, 1'b1);
    chk("rstmid_no_done", done_cnt - dc, 0);
    chk("rstmid_no_err",  err_cnt - ec, 0);

    send(8'hF4);
    good_frame("f4", bits);

    // tx_valid held with changing data: each accept yields one frame of the
    // byte captured at that accept.
    dc = done_cnt;
    chk("hold_queue_empty", acc_q.size(), 0);
    fork
      begin
        dev_frame(1'b1, 0, bits, inh);
        dev_frame(1'b1, 0, bits2, inh);
      end
      begin
        @(posedge clk); #1;
        bus.tx_data  = 8'($urandom);
        bus.tx_valid = 1'b1;
        tn = 0;
        while (acc_q.size() < 2 && tn < LIM) begin
          @(posedge clk); #1;
          bus.tx_data = 8'($urandom);
          tn++;
        end
        bus.tx_valid = 1'b0;
      end
    join
    chk("hold_inhibit2_len", inh, INH);
    wait_done("hold");
    chk("hold_accepts", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      chk("hold_wire1", bits,  frame_bits(acc_q[0]));
      chk("hold_wire2", bits2, frame_bits(acc_q[1]));
    end
    repeat (50) @(negedge clk);
    chk("hold_done_cnt", done_cnt - dc, 2);
    chk("hold_idle",     bus.busy, 1'b0);

    chk("never_done_and_err", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
